// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: 2-flop synchroniser followed by a stability
// counter that commits a new level only after it has held for STABLE_CYCLES.
module sw_debounce #(
  parameter int unsigned N             = 10,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] SW_raw,
  output logic [N-1:0] SW,
  output logic [N-1:0] changed_mask,
  output logic         changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N-1:0]            s1_q, s1_d;
  logic [N-1:0]            s2_q, s2_d;
  logic [N-1:0]            sw_q, sw_d;
  logic [N-1:0]            mask_q, mask_d;
  logic                    changed_q, changed_d;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = SW_raw;
    s2_d   = s1_q;
    sw_d   = sw_q;
    mask_d = '0;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < N; i++) begin
      // Any sample agreeing with the output restarts the stability window.
      if (s2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        sw_d[i]   = s2_q[i];
        cnt_d[i]  = '0;
        mask_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    changed_d = |mask_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sw_q      <= '0;
      mask_q    <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sw_q      <= sw_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign SW           = sw_q;
  assign changed_mask = mask_q;
  assign changed      = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with STABLE_CYCLES=4: directed vector table, hand
// sequences for reset corners, and random stimulus against a history model.
module tb_sw_debounce;

  localparam int N      = 10;
  localparam int STABLE = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] SW_raw;
  logic [N-1:0] SW;
  logic [N-1:0] changed_mask;
  logic         changed;

  sw_debounce #(
    .N            (N),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SW_raw      (SW_raw),
    .SW          (SW),
    .changed_mask(changed_mask),
    .changed     (changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int pulses;

  // Model: raw level at every edge since reset; the filter at edge k sees the
  // raw level of edge k-2, and a bit flips once the last STABLE such samples
  // (all after its previous update) disagree with the current output.
  logic [N-1:0] hist[$];
  logic [N-1:0] synq[$];
  int           last_upd[N];
  logic [N-1:0] m_sw, m_mask;
  logic         m_chg;

  typedef struct {
    logic [N-1:0] raw;
    int unsigned  hold;
    logic [N-1:0] exp_sw;
    int unsigned  exp_pulses;
    logic [N-1:0] exp_mask;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    synq.delete();
    for (int i = 0; i < N; i++) last_upd[i] = -1;
    m_sw   = '0;
    m_mask = '0;
    m_chg  = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] raw);
    int k;
    logic all_diff;
    logic [N-1:0] syn;
    syn = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    hist.push_back(raw);
    synq.push_back(syn);
    k = synq.size() - 1;
    m_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (k - last_upd[i] >= STABLE) begin
        all_diff = 1'b1;
        for (int j = k - STABLE + 1; j <= k; j++)
          if (synq[j][i] == m_sw[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_mask[i]   = 1'b1;
          last_upd[i] = k;
        end
      end
    end
    m_sw  = m_sw ^ m_mask;
    m_chg = |m_mask;
  endtask

  // Drive raw just after an edge, advance one edge, check 1 time unit later.
  task automatic step(input logic [N-1:0] raw);
    SW_raw = raw;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge(raw);
    #1;
    chk("sw",      32'(SW),           32'(m_sw));
    chk("mask",    32'(changed_mask), 32'(m_mask));
    chk("changed", 32'(changed),      32'(m_chg));
    if (changed === 1'b1) pulses++;
  endtask

  initial begin
    logic [N-1:0] r;
    int unsigned  hold;

    tbl.push_back('{10'h000, 6, 10'h000, 1, 10'h3FF});
    tbl.push_back('{10'h001, 6, 10'h001, 1, 10'h001});
    tbl.push_back('{10'h000, 6, 10'h000, 1, 10'h001});
    tbl.push_back('{10'h020, 3, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h000, 8, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h300, 5, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h300, 1, 10'h300, 1, 10'h300});
    tbl.push_back('{10'h000, 6, 10'h000, 1, 10'h300});
    tbl.push_back('{10'h004, 4, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h000, 2, 10'h004, 1, 10'h004});
    tbl.push_back('{10'h000, 4, 10'h000, 1, 10'h004});
    tbl.push_back('{10'h008, 2, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h000, 2, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h008, 2, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h000, 2, 10'h000, 0, 10'h000});
    tbl.push_back('{10'h008, 6, 10'h008, 1, 10'h008});
    tbl.push_back('{10'h000, 6, 10'h000, 1, 10'h008});

    rst_n  = 1'b0;
    SW_raw = 10'h3FF;
    model_reset();
    #1;
    chk("reset_sw", 32'(SW), 32'h0);
    chk("reset_changed", 32'(changed), 32'h0);
    repeat (3) step(10'h3FF);

    // Release mid-cycle; all bits high must appear on the 6th edge.
    #3 rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step(10'h3FF);
      if (e == 5) chk("rel_sw_e5", 32'(SW), 32'h0);
      if (e == 6) begin
        chk("rel_sw_e6", 32'(SW), 32'h3FF);
        chk("rel_mask_e6", 32'(changed_mask), 32'h3FF);
      end
      if (e == 7) chk("rel_mask_e7", 32'(changed_mask), 32'h0);
    end

    foreach (tbl[v]) begin
      pulses = 0;
      for (int unsigned c = 0; c < tbl[v].hold; c++) step(tbl[v].raw);
      chk($sformatf("tbl%0d_sw", v), 32'(SW), 32'(tbl[v].exp_sw));
      chk($sformatf("tbl%0d_mask", v), 32'(changed_mask), 32'(tbl[v].exp_mask));
      chk($sformatf("tbl%0d_pulses", v), 32'(pulses), 32'(tbl[v].exp_pulses));
    end

    r = '0;
    for (int t = 0; t < 300; t++) begin
      r    = r ^ N'($urandom & $urandom & $urandom);
      hold = (t % 10 == 0) ? $urandom_range(6, 12) : $urandom_range(1, 6);
      repeat (hold) step(r);
    end

    // Reset two edges into a pending change must clear outputs at once.
    repeat (12) step(10'h3FF);
    chk("pre_mid_sw", 32'(SW), 32'h3FF);
    repeat (2) step(10'h3FE);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_sw", 32'(SW), 32'h0);
    chk("mid_rst_mask", 32'(changed_mask), 32'h0);
    chk("mid_rst_changed", 32'(changed), 32'h0);
    repeat (2) step(10'h3FE);
    #3 rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(10'h3FE);
      if (e == 5) chk("mid_rel_sw_e5", 32'(SW), 32'h0);
      if (e == 6) chk("mid_rel_sw_e6", 32'(SW), 32'h3FE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
